// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family.
//   state_e      : sequential multiplier FSM states
//   booth_sel_t  : recoded partial-product select {neg, two, zero}
//   SEL_*        : the five legal select codes
//   iter_count() : radix-4 steps needed for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_sel_t;

  localparam booth_sel_t SEL_ZERO = booth_sel_t'(3'b001);
  localparam booth_sel_t SEL_P1   = booth_sel_t'(3'b000);
  localparam booth_sel_t SEL_P2   = booth_sel_t'(3'b010);
  localparam booth_sel_t SEL_M1   = booth_sel_t'(3'b100);
  localparam booth_sel_t SEL_M2   = booth_sel_t'(3'b110);

  // Operands are extended by two bits before recoding, hence (width+2)/2 digits.
  function automatic int unsigned iter_count(input int unsigned width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth digit recoder (combinational).
//   window : {q[i+1], q[i], q[i-1]}
//   sel_c  : {neg, two, zero} partial-product select
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0]  window,
  output booth_sel_t  sel_c
);

  always_comb begin
    sel_c = SEL_ZERO;
    case (window)
      3'b000, 3'b111: sel_c = SEL_ZERO;
      3'b001, 3'b010: sel_c = SEL_P1;
      3'b011:         sel_c = SEL_P2;
      3'b100:         sel_c = SEL_M2;
      3'b101, 3'b110: sel_c = SEL_M1;
      default:        sel_c = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (m, q, signed_mode)
//   out_valid / out_ready : product handshake; product held until consumed
//   busy                  : high while iterating
module booth_r4_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned EW   = WIDTH + 2;        // extended operand width
  localparam int unsigned AW   = WIDTH + 3;        // accumulator width (holds +/-2M)
  localparam int unsigned ITER = iter_count(WIDTH);
  localparam int unsigned CW   = $clog2(ITER + 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
  end

  state_e          state_q, state_d;
  logic [EW-1:0]   m_q, q_q;
  logic            q_m1_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   count_q;

  booth_sel_t      sel_c;
  logic [AW-1:0]   m_ax_c, pp_mag_c, pp_c, sum_c, acc_nx_c;
  logic [EW-1:0]   q_nx_c;
  logic [2*WIDTH-1:0] prod_nx_c;

  booth_r4_recode u_recode (
    .window ({q_q[1:0], q_m1_q}),
    .sel_c  (sel_c)
  );

  // One Booth step: add selected partial product, then arithmetic shift {acc,q} by 2.
  always_comb begin
    m_ax_c    = {m_q[EW-1], m_q};
    pp_mag_c  = sel_c.two ? {m_q, 1'b0} : m_ax_c;
    pp_c      = '0;
    if (!sel_c.zero) begin
      pp_c = sel_c.neg ? AW'((~pp_mag_c) + AW'(1)) : pp_mag_c;
    end
    sum_c     = AW'(acc_q + pp_c);
    acc_nx_c  = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
    q_nx_c    = {sum_c[1:0], q_q[EW-1:2]};
    // Full result is {acc,q}; only the low 2*WIDTH bits are significant.
    prod_nx_c = {acc_nx_c[WIDTH-3:0], q_nx_c};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)              state_d = ST_CALC;
      ST_CALC: if (count_q == CW'(1))     state_d = ST_DONE;
      ST_DONE: if (out_ready)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // State register, registered handshake flags and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      busy      <= (state_d == ST_CALC);
      out_valid <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            m_q     <= signed_mode ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
            q_q     <= signed_mode ? {{2{q[WIDTH-1]}}, q} : {2'b00, q};
            q_m1_q  <= 1'b0;
            acc_q   <= '0;
            count_q <= CW'(ITER);
          end
        end
        ST_CALC: begin
          acc_q   <= acc_nx_c;
          q_q     <= q_nx_c;
          q_m1_q  <= q_q[1];
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            product <= prod_nx_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
module tb_booth_r4_mult_seq;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_in_valid, a_in_ready, a_sm, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_m, a_q;
  logic [63:0] a_product;

  logic        b_in_valid, b_in_ready, b_sm, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_m, b_q;
  logic [15:0] b_product;

  int errors = 0;
  int checks = 0;

  logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80,
                            8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h40};

  always #5 clk = ~clk;

  booth_r4_mult_seq #(.WIDTH(32)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .m(a_m), .q(a_q), .signed_mode(a_sm), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .product(a_product), .busy(a_busy)
  );

  booth_r4_mult_seq #(.WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .m(b_m), .q(b_q), .signed_mode(b_sm), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .product(b_product), .busy(b_busy)
  );

  // Accept one op on the 32-bit unit and wait (bounded) for out_valid; does not consume.
  task automatic run_a(input logic [31:0] mm, input logic [31:0] qq, input logic sm,
                       output logic [63:0] prod, output int lat);
    int guard;
    guard = 0;
    while (!a_in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    a_m = mm; a_q = qq; a_sm = sm; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_m = 32'h5A5A_1234; a_q = 32'hDEAD_BEEF; a_sm = ~sm;
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    prod = a_product;
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_product !== 64'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", a_product); end
    checks++; if (b_in_ready !== 1'b1 || b_product !== 16'h0) begin errors++; $display("FAIL reset_b got=%b/%h exp=1/0000", b_in_ready, b_product); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_basic();
    logic [63:0] p; int lat;
    run_a(32'd7, 32'hFFFF_FFFD, 1'b1, p, lat);
    checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL t1_prod got=%h exp=ffffffffffffffeb", p); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL t1_latency got=%0d exp=17", lat); end
    release_a();
  endtask

  task automatic test_modes();
    logic [63:0] p; int lat;
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat);
    checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL t2_unsigned_max got=%h exp=fffffffe00000001", p); end
    release_a();
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, lat);
    checks++; if (p !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL t2_signed_m1 got=%h exp=0000000000000001", p); end
    release_a();
  endtask

  task automatic test_extremes();
    logic [63:0] p; int lat;
    run_a(32'h8000_0000, 32'h8000_0000, 1'b1, p, lat);
    checks++; if (p !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL t3_minsq got=%h exp=4000000000000000", p); end
    release_a();
    run_a(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, p, lat);
    checks++; if (p !== 64'hC000_0000_8000_0000) begin errors++; $display("FAIL t3_minmax got=%h exp=c000000080000000", p); end
    release_a();
  endtask

  task automatic test_backpressure();
    logic [63:0] p; int lat;
    run_a(32'd5, 32'd6, 1'b1, p, lat);
    checks++; if (p !== 64'd30) begin errors++; $display("FAIL t4_prod got=%h exp=1e", p); end
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_m = 32'd9; a_q = 32'd9; a_sm = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_product !== 64'd30 || a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL t4_hold cyc=%0d got ov=%b p=%h ir=%b bz=%b exp ov=1 p=1e ir=0 bz=0",
                 i, a_out_valid, a_product, a_in_ready, a_busy);
      end
    end
    a_in_valid = 1'b0;
    release_a();
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL t4_release got ov=%b ir=%b exp ov=0 ir=1", a_out_valid, a_in_ready); end
    checks++; if (a_product !== 64'd30) begin errors++; $display("FAIL t4_product_kept got=%h exp=1e", a_product); end
    @(posedge clk); #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t4_no_capture got busy=%b exp=0", a_busy); end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] p; int lat; bit seen;
    a_m = 32'h0000_1234; a_q = 32'h10; a_sm = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL t5_calc_flags got bz=%b ir=%b exp bz=1 ir=0", a_busy, a_in_ready); end
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL t5_idle got ir=%b bz=%b ov=%b exp ir=1 bz=0 ov=0", a_in_ready, a_busy, a_out_valid); end
    checks++; if (a_product !== 64'h0) begin errors++; $display("FAIL t5_product_cleared got=%h exp=0", a_product); end
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (a_out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t5_no_out_valid got=1 exp=0"); end
    run_a(32'd3, 32'd5, 1'b1, p, lat);
    checks++; if (p !== 64'd15) begin errors++; $display("FAIL t5_after_reset got=%h exp=f", p); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL t5_latency got=%0d exp=17", lat); end
    release_a();
  endtask

  task automatic test_back_to_back();
    int sa, sb, lat, guard;
    logic [15:0] exp;
    b_out_ready = 1'b1;
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          if (md == 1) begin sa = $signed(vals[i]); sb = $signed(vals[j]); end
          else begin sa = int'(vals[i]); sb = int'(vals[j]); end
          exp = 16'(sa * sb);
          guard = 0;
          while (!b_in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
          b_m = vals[i]; b_q = vals[j]; b_sm = (md == 1); b_in_valid = 1'b1;
          @(posedge clk); #1;
          b_in_valid = 1'b0; b_m = 8'hC3; b_q = 8'h3C;
          lat = 0;
          while (!b_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
          checks++;
          if (b_product !== exp) begin
            errors++;
            $display("FAIL t6_prod mode=%0d m=%h q=%h got=%h exp=%h", md, vals[i], vals[j], b_product, exp);
          end
          checks++;
          if (lat !== 5) begin
            errors++;
            $display("FAIL t6_latency mode=%0d m=%h q=%h got=%0d exp=5", md, vals[i], vals[j], lat);
          end
        end
      end
    end
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_m = '0; a_q = '0; a_sm = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_m = '0; b_q = '0; b_sm = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_signed_basic();
    test_modes();
    test_extremes();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
